// File: rtl/sram_arb_pkg.sv
// Shared encodings and default geometry for the board SRAM share arbiter.
package sram_arb_pkg;

    localparam int unsigned SRAM_ADDR_W   = 19;
    localparam int unsigned SRAM_DATA_W   = 2;
    localparam int unsigned RUN_W         = 4;
    localparam logic [18:0] SRAM_CFG_ADDR = 19'h08FD5;

    typedef enum logic [2:0] {
        ST_CFG,
        ST_IDLE,
        ST_RD,
        ST_WR_SU,
        ST_WR,
        ST_WR_HD
    } arb_state_e;

endpackage

// File: rtl/sram_arb_pick.sv
// Scan-priority pick with vector anti-starvation and the next run-count value.
module sram_arb_pick
    import sram_arb_pkg::*;
#(
    parameter int unsigned MAX_RUN = 4
) (
    input  logic             en_i,
    input  logic             scan_req_i,
    input  logic             vec_req_i,
    input  logic             scan_mask_i,
    input  logic             vec_mask_i,
    input  logic [RUN_W-1:0] run_i,
    output logic             grant_scan_o,
    output logic             grant_vec_o,
    output logic [RUN_W-1:0] run_o
);

    logic vec_starve;

    // A masked (just-acked) scan still holds priority, so vec only slips in when starved.
    always_comb begin
        vec_starve   = vec_req_i && !vec_mask_i && (run_i == RUN_W'(MAX_RUN));
        grant_scan_o = en_i && scan_req_i && !scan_mask_i && !vec_starve;
        grant_vec_o  = en_i && vec_req_i && !vec_mask_i && (vec_starve || !scan_req_i);
        run_o        = run_i;
        if (en_i) begin
            if (grant_vec_o || !vec_req_i) begin
                run_o = '0;
            end else if (grant_scan_o && (run_i < RUN_W'(MAX_RUN))) begin
                run_o = run_i + RUN_W'(1);
            end
        end
    end

endmodule

// File: rtl/sram_share_arb.sv
// Board SRAM share: post-reset config read, scan reads, vector writes.
// Optional SRAM_ARB_STATS_EN adds vec_stall_cnt / scan_grant_cnt ports.
module sram_share_arb
    import sram_arb_pkg::*;
#(
    parameter int unsigned           ADDR_W   = SRAM_ADDR_W,
    parameter int unsigned           DATA_W   = SRAM_DATA_W,
    parameter int unsigned           ACC_CYC  = 2,
    parameter logic [ADDR_W-1:0]     CFG_ADDR = ADDR_W'(SRAM_CFG_ADDR),
    parameter int unsigned           MAX_RUN  = 4
) (
    input  logic              clk_25,
    input  logic              reset,
    input  logic              scan_req,
    input  logic [ADDR_W-1:0] scan_addr,
    output logic              scan_ack,
    output logic [DATA_W-1:0] scan_rdata,
    input  logic              vec_req,
    input  logic [ADDR_W-1:0] vec_addr,
    input  logic [DATA_W-1:0] vec_wdata,
    output logic              vec_ack,
    output logic [1:0]        scandblctrl,
    output logic              cfg_valid,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [DATA_W-1:0] sram_din,
    output logic [DATA_W-1:0] sram_dout,
    output logic              sram_oe,
    output logic              sram_we
`ifdef SRAM_ARB_STATS_EN
    ,
    output logic [15:0]       vec_stall_cnt,
    output logic [15:0]       scan_grant_cnt
`endif
);

    arb_state_e        state_q, state_d;
    logic [2:0]        acc_cnt_q, acc_cnt_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [ADDR_W-1:0] sram_addr_q;
    logic [DATA_W-1:0] sram_dout_q, scan_rdata_q;
    logic              we_q, we_d, oe_q, oe_d;
    logic              scan_ack_q, scan_ack_d, vec_ack_q, vec_ack_d;
    logic [1:0]        scandbl_q;
    logic              cfg_valid_q, cfg_load;
    logic              acc_last, grant_scan, grant_vec;

    assign acc_last = (acc_cnt_q == 3'(ACC_CYC - 1));

    sram_arb_pick #(
        .MAX_RUN (MAX_RUN)
    ) u_pick (
        .en_i         (state_q == ST_IDLE),
        .scan_req_i   (scan_req),
        .vec_req_i    (vec_req),
        .scan_mask_i  (scan_ack_q),
        .vec_mask_i   (vec_ack_q),
        .run_i        (run_q),
        .grant_scan_o (grant_scan),
        .grant_vec_o  (grant_vec),
        .run_o        (run_d)
    );

    always_ff @(posedge clk_25) begin
        if (reset) begin
            state_q <= ST_CFG;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CFG:   if (acc_last) state_d = ST_IDLE;
            ST_IDLE: begin
                if (grant_scan) begin
                    state_d = ST_RD;
                end else if (grant_vec) begin
                    state_d = ST_WR_SU;
                end
            end
            ST_RD:    if (acc_last) state_d = ST_IDLE;
            ST_WR_SU: state_d = ST_WR;
            ST_WR:    if (acc_last) state_d = ST_WR_HD;
            ST_WR_HD: state_d = ST_IDLE;
            default:  state_d = ST_CFG;
        endcase
    end

    // Pin strobes are decoded from the next state so they register glitch-free with the address.
    always_comb begin
        we_d       = (state_d == ST_WR);
        oe_d       = (state_d inside {ST_WR_SU, ST_WR, ST_WR_HD});
        scan_ack_d = (state_q == ST_RD) && acc_last;
        vec_ack_d  = (state_q == ST_WR_HD);
        cfg_load   = (state_q == ST_CFG) && acc_last;
        acc_cnt_d  = '0;
        if ((state_q inside {ST_CFG, ST_RD, ST_WR}) && !acc_last) begin
            acc_cnt_d = acc_cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk_25) begin
        if (reset) begin
            acc_cnt_q    <= '0;
            run_q        <= '0;
            sram_addr_q  <= CFG_ADDR;
            sram_dout_q  <= '0;
            scan_rdata_q <= '0;
            we_q         <= 1'b0;
            oe_q         <= 1'b0;
            scan_ack_q   <= 1'b0;
            vec_ack_q    <= 1'b0;
            scandbl_q    <= 2'b00;
            cfg_valid_q  <= 1'b0;
        end else begin
            acc_cnt_q  <= acc_cnt_d;
            run_q      <= run_d;
            we_q       <= we_d;
            oe_q       <= oe_d;
            scan_ack_q <= scan_ack_d;
            vec_ack_q  <= vec_ack_d;
            if (grant_scan) begin
                sram_addr_q <= scan_addr;
            end else if (grant_vec) begin
                sram_addr_q <= vec_addr;
                sram_dout_q <= vec_wdata;
            end
            if (scan_ack_d) begin
                scan_rdata_q <= sram_din;
            end
            if (cfg_load) begin
                scandbl_q   <= sram_din[1:0];
                cfg_valid_q <= 1'b1;
            end
        end
    end

`ifdef SRAM_ARB_STATS_EN
    logic [15:0] vec_stall_q, scan_grant_q;

    always_ff @(posedge clk_25) begin
        if (reset) begin
            vec_stall_q  <= '0;
            scan_grant_q <= '0;
        end else begin
            if (vec_req && !grant_vec && (vec_stall_q != 16'hFFFF)) begin
                vec_stall_q <= vec_stall_q + 16'd1;
            end
            if (grant_scan) begin
                scan_grant_q <= scan_grant_q + 16'd1;
            end
        end
    end

    assign vec_stall_cnt  = vec_stall_q;
    assign scan_grant_cnt = scan_grant_q;
`endif

    assign scan_ack    = scan_ack_q;
    assign vec_ack     = vec_ack_q;
    assign scan_rdata  = scan_rdata_q;
    assign scandblctrl = scandbl_q;
    assign cfg_valid   = cfg_valid_q;
    assign sram_addr   = sram_addr_q;
    assign sram_dout   = sram_dout_q;
    assign sram_oe     = oe_q;
    assign sram_we     = we_q;

endmodule

// File: tb/tb_sram_share_arb.sv
// Directed bench for sram_share_arb with a behavioural async SRAM (ACC_CYC=2, MAX_RUN=4).
module tb_sram_share_arb;

    localparam logic [18:0] CFG_A = 19'h08FD5;

    logic        clk_25 = 1'b0;
    logic        reset = 1'b1;
    logic        scan_req = 1'b0;
    logic [18:0] scan_addr = '0;
    logic        scan_ack;
    logic [1:0]  scan_rdata;
    logic        vec_req = 1'b0;
    logic [18:0] vec_addr = '0;
    logic [1:0]  vec_wdata = '0;
    logic        vec_ack;
    logic [1:0]  scandblctrl;
    logic        cfg_valid;
    logic [18:0] sram_addr;
    logic [1:0]  sram_din = '0;
    logic [1:0]  sram_dout;
    logic        sram_oe;
    logic        sram_we;
`ifdef SRAM_ARB_STATS_EN
    logic [15:0] vec_stall_cnt;
    logic [15:0] scan_grant_cnt;
`endif

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [1:0] mem [logic [18:0]];

    always #5 clk_25 = ~clk_25;

    sram_share_arb #(
        .ACC_CYC (2),
        .MAX_RUN (4)
    ) dut (
        .clk_25      (clk_25),
        .reset       (reset),
        .scan_req    (scan_req),
        .scan_addr   (scan_addr),
        .scan_ack    (scan_ack),
        .scan_rdata  (scan_rdata),
        .vec_req     (vec_req),
        .vec_addr    (vec_addr),
        .vec_wdata   (vec_wdata),
        .vec_ack     (vec_ack),
        .scandblctrl (scandblctrl),
        .cfg_valid   (cfg_valid),
        .sram_addr   (sram_addr),
        .sram_din    (sram_din),
        .sram_dout   (sram_dout),
        .sram_oe     (sram_oe),
        .sram_we     (sram_we)
`ifdef SRAM_ARB_STATS_EN
        ,
        .vec_stall_cnt  (vec_stall_cnt),
        .scan_grant_cnt (scan_grant_cnt)
`endif
    );

    // Async SRAM: write while strobed, then present read data for the current address.
    always @(negedge clk_25) begin
        if (sram_we && sram_oe) mem[sram_addr] = sram_dout;
        sram_din = mem.exists(sram_addr) ? mem[sram_addr] : 2'b00;
    end

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk_25);
        n_cmp++; if (sram_addr !== CFG_A) begin n_bad++; $display("FAIL rst_addr got %h want %h", sram_addr, CFG_A); end
        n_cmp++; if ({scan_ack, vec_ack, sram_we, sram_oe, cfg_valid} !== 5'b0) begin n_bad++; $display("FAIL rst_ctl got %b want 00000", {scan_ack, vec_ack, sram_we, sram_oe, cfg_valid}); end
        n_cmp++; if ({sram_dout, scan_rdata, scandblctrl} !== 6'b0) begin n_bad++; $display("FAIL rst_data got %b want 000000", {sram_dout, scan_rdata, scandblctrl}); end
        reset = 1'b0;
        @(negedge clk_25);
        n_cmp++; if (cfg_valid !== 1'b0) begin n_bad++; $display("FAIL cfg_early got %b want 0", cfg_valid); end
        n_cmp++; if (sram_addr !== CFG_A) begin n_bad++; $display("FAIL cfg_addr got %h want %h", sram_addr, CFG_A); end
        @(negedge clk_25);
        n_cmp++; if (cfg_valid !== 1'b1) begin n_bad++; $display("FAIL cfg_valid got %b want 1", cfg_valid); end
        n_cmp++; if (scandblctrl !== 2'b10) begin n_bad++; $display("FAIL cfg_word got %b want 10", scandblctrl); end
        n_cmp++; if ({scan_ack, vec_ack} !== 2'b00) begin n_bad++; $display("FAIL cfg_noack got %b want 00", {scan_ack, vec_ack}); end
    endtask

    task automatic test_scan_read(input logic [18:0] a, input logic [1:0] exp);
        int lat;
        logic got;
        lat = 0;
        got = 1'b0;
        scan_addr = a;
        scan_req  = 1'b1;
        for (int i = 1; i <= 12 && !got; i++) begin
            @(negedge clk_25);
            if (i == 1) begin
                n_cmp++; if (sram_addr !== a) begin n_bad++; $display("FAIL rd_addr got %h want %h", sram_addr, a); end
            end
            if (scan_ack) begin got = 1'b1; lat = i; end
        end
        scan_req = 1'b0;
        n_cmp++; if (got !== 1'b1) begin n_bad++; $display("FAIL rd_timeout got %b want 1", got); end
        n_cmp++; if (lat != 3) begin n_bad++; $display("FAIL rd_latency got %0d want 3", lat); end
        n_cmp++; if (scan_rdata !== exp) begin n_bad++; $display("FAIL rd_data got %b want %b", scan_rdata, exp); end
        @(negedge clk_25);
        n_cmp++; if (scan_ack !== 1'b0) begin n_bad++; $display("FAIL rd_pulse got %b want 0", scan_ack); end
    endtask

    task automatic test_vec_write();
        int we_cnt, lat, first_oe, last_oe, first_we, last_we, bad_pins;
        we_cnt = 0; lat = 0; first_oe = -1; last_oe = -1; first_we = -1; last_we = -1; bad_pins = 0;
        vec_addr  = 19'h00200;
        vec_wdata = 2'b11;
        vec_req   = 1'b1;
        for (int i = 1; i <= 12 && lat == 0; i++) begin
            @(negedge clk_25);
            if (sram_oe) begin
                if (first_oe < 0) first_oe = i;
                last_oe = i;
                if (sram_addr !== 19'h00200 || sram_dout !== 2'b11) bad_pins++;
            end
            if (sram_we) begin
                if (first_we < 0) first_we = i;
                last_we = i;
                we_cnt++;
            end
            if (vec_ack) lat = i;
        end
        vec_req = 1'b0;
        n_cmp++; if (lat != 5) begin n_bad++; $display("FAIL wr_latency got %0d want 5", lat); end
        n_cmp++; if (we_cnt != 2) begin n_bad++; $display("FAIL wr_we_cycles got %0d want 2", we_cnt); end
        n_cmp++; if (first_oe != 1 || first_we != 2) begin n_bad++; $display("FAIL wr_setup got oe@%0d we@%0d want oe@1 we@2", first_oe, first_we); end
        n_cmp++; if (last_we != 3 || last_oe != 4) begin n_bad++; $display("FAIL wr_hold got we@%0d oe@%0d want we@3 oe@4", last_we, last_oe); end
        n_cmp++; if (bad_pins != 0) begin n_bad++; $display("FAIL wr_pins got %0d bad cycles want 0", bad_pins); end
        n_cmp++; if (sram_oe !== 1'b0) begin n_bad++; $display("FAIL wr_oe_off got %b want 0", sram_oe); end
        test_scan_read(19'h00200, 2'b11);
    endtask

    task automatic test_back_to_back();
        int n, both, grants;
        logic [9:0] pat;
        logic prev_oe;
`ifdef SRAM_ARB_STATS_EN
        logic [15:0] stall0;
        stall0 = vec_stall_cnt;
`endif
        n = 0; both = 0; grants = 0; pat = '0; prev_oe = sram_oe;
        scan_addr = 19'h00100;
        vec_addr  = 19'h00300;
        vec_wdata = 2'b01;
        scan_req  = 1'b1;
        vec_req   = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk_25);
            if (scan_ack && vec_ack) both++;
            if (scan_ack && n < 10) begin pat[n] = 1'b0; n++; end
            else if (vec_ack && n < 10) begin pat[n] = 1'b1; n++; end
            if (sram_oe && !prev_oe) grants++;
            prev_oe = sram_oe;
        end
        n_cmp++; if (n != 10) begin n_bad++; $display("FAIL b2b_ack_count got %0d want 10", n); end
        n_cmp++; if (pat !== 10'h210) begin n_bad++; $display("FAIL b2b_pattern got %b want 1000010000", pat); end
        n_cmp++; if (both != 0) begin n_bad++; $display("FAIL b2b_dual_ack got %0d want 0", both); end
`ifdef SRAM_ARB_STATS_EN
        n_cmp++; if (vec_stall_cnt - stall0 !== 16'(60 - grants)) begin n_bad++; $display("FAIL stats_stall got %0d want %0d", vec_stall_cnt - stall0, 60 - grants); end
`endif
        scan_req = 1'b0;
        vec_req  = 1'b0;
        repeat (12) @(negedge clk_25);
    endtask

    task automatic test_reset_mid_write();
        logic seen_we;
        int acks;
        logic cv1, cv2;
        seen_we = 1'b0;
        acks = 0;
        vec_addr  = 19'h00400;
        vec_wdata = 2'b01;
        vec_req   = 1'b1;
        for (int i = 1; i <= 12 && !seen_we; i++) begin
            @(negedge clk_25);
            if (sram_we) seen_we = 1'b1;
        end
        n_cmp++; if (seen_we !== 1'b1) begin n_bad++; $display("FAIL mid_we_timeout got %b want 1", seen_we); end
        reset = 1'b1;
        @(negedge clk_25);
        n_cmp++; if ({sram_we, sram_oe} !== 2'b00) begin n_bad++; $display("FAIL mid_strobes got %b want 00", {sram_we, sram_oe}); end
        n_cmp++; if (sram_addr !== CFG_A) begin n_bad++; $display("FAIL mid_addr got %h want %h", sram_addr, CFG_A); end
        reset   = 1'b0;
        vec_req = 1'b0;
        cv1 = 1'bx; cv2 = 1'bx;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk_25);
            if (vec_ack) acks++;
            if (i == 1) cv1 = cfg_valid;
            if (i == 2) cv2 = cfg_valid;
        end
        n_cmp++; if (acks != 0) begin n_bad++; $display("FAIL mid_no_ack got %0d want 0", acks); end
        n_cmp++; if ({cv1, cv2} !== 2'b01) begin n_bad++; $display("FAIL mid_cfg_rerun got %b want 01", {cv1, cv2}); end
        n_cmp++; if (scandblctrl !== 2'b10) begin n_bad++; $display("FAIL mid_cfg_word got %b want 10", scandblctrl); end
    endtask

    initial begin
        mem[CFG_A]       = 2'b10;
        mem[19'h00100]   = 2'b01;
        test_reset();
        test_scan_read(19'h00100, 2'b01);
        test_vec_write();
        test_back_to_back();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
